full_st1_act_out: RTL
=====================

Name: full_st1_act_out

Overview:
- Sits directly downstream of the stage-1 full-layer controller.
- Consumes its forward output stream (stage_1_data_out, with fst/vld/rdy) and applies the per-vector activation (bypass or ReLU).
- Buffers results in a small FIFO and presents them as the stage-2 input stream. Alongside each element it emits a ReLU derivative mask bit for the back-propagation path.
- Checks vector framing and keeps a completed-vector count.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- VEC_LEN, 16, elements per vector; 1..65535.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- stage_1_data_out  in  float_24_8  forward data element.
- stage_1_data_out_fst  in  1  first element of a vector.
- stage_1_data_out_vld  in  1  element valid.
- stage_1_data_out_rdy  out  1  block can accept.
- act_mode  in  1  0 = bypass, 1 = ReLU; sampled per vector.
- stage_2_data  out  float_24_8  activated element.
- stage_2_data_fst  out  1  first element of output vector.
- stage_2_data_mask  out  1  ReLU derivative: 1 = element passed, 0 = zeroed.
- stage_2_data_vld  out  1  output valid.
- stage_2_data_rdy  in  1  downstream accepts.
- clear  in  1  synchronous clear of frame_err and vec_count.
- frame_err  out  1  sticky framing-violation flag.
- vec_count  out  16  completed input vectors, wraps.
- zero_count  out  16  see Optional Feature.

Behaviour:
- Reset (reset=0, async): FIFO empty, state WAIT_FST, index counter 0.
  - Output values: stage_1_data_out_rdy=0 while reset asserted, 1 from the first clock edge after release.
  - All other outputs 0.
- Handshakes: a transfer occurs on a clock edge with vld&rdy.
  - stage_1_data_out_rdy = !full. There is no same-cycle write-through when full, even if a read occurs.
  - stage_2_data_vld = !empty. stage_2_data/fst/mask reflect the FIFO head and hold stable while vld&!rdy.
- Latency: an element accepted at edge N is visible at the output after edge N (one cycle) when the FIFO was empty.
- Activation is applied at FIFO write:
  - ReLU with sign=1: stored value is all-zero float_24_8, mask=0.
  - ReLU with sign=0: value is passed unchanged, mask=1.
  - Bypass: value is passed unchanged, mask=1.
  - ReLU of -0 yields +0 with mask=0.
- Mode latch: act_mode is captured on an accepted element with fst=1 and applied to the whole vector.
- Framing FSM, states WAIT_FST and IN_VEC:
  - WAIT_FST, accepted fst=1: write the element (fst=1), index=1, latch mode. Go to IN_VEC, or if VEC_LEN=1 stay in WAIT_FST and increment vec_count.
  - WAIT_FST, accepted fst=0: element is consumed (rdy honoured), not written. frame_err←1.
  - IN_VEC, accepted fst=0: write the element, index++. When index reaches VEC_LEN: increment vec_count, go to WAIT_FST.
  - IN_VEC, accepted fst=1: frame_err←1. The partial vector is abandoned without a vec_count increment. The element is treated as a new first element (written, index=1, mode relatched).
- clear: clears frame_err and vec_count (and zero_count). If clear and a setting/incrementing event coincide in the same cycle, the event wins.
- Counters: vec_count and zero_count wrap from 0xFFFF to 0.
- Full/empty: a simultaneous read and write with the FIFO neither full nor empty keeps occupancy unchanged. Pointers are log2(DEPTH)+1 bits, so full/empty is decided by comparing the wrap bits.

Optional Feature:
- Macro FULL_ST1_ACT_OUT_STATS_EN.
- Defined: zero_count increments on every FIFO write with mask=0. It is cleared by reset and clear.
- Undefined: zero_count is tied to 0 and no counter logic is instantiated.

Decomposition:
- Shared package holds the float_24_8 typedef, the constant FLOAT_24_8_ZERO, and the enum act_mode_t {ACT_BYPASS, ACT_RELU}.
- One sub-module: full_st1_act_fifo, a generic synchronous FIFO parameterised by width and depth, storing {float_24_8, fst, mask}.
- Framing FSM and activation stay in the top module.

Test Plan:
- ReLU vector: VEC_LEN=4, mode=1, inputs {+1.0, -2.0, +3.0, -0.0}, fst on the first, stage_2_data_rdy=1.
  -> Outputs {+1.0, 0, +3.0, 0}, mask 1,0,1,0, fst on the first only, each one cycle after input; vec_count=1.
- Backpressure: stage_2_data_rdy=0, stream 10 elements, DEPTH=8.
  -> rdy drops after 8 accepts; head stays stable. Raise rdy -> all 10 delivered in order, none lost or duplicated.
- Orphan element: after reset, send fst=0.
  -> Consumed, no output, frame_err=1. A following fst=1 vector processes normally and vec_count increments.
- Early fst: send 2 elements of a 4-element vector, then fst=1 with mode=0.
  -> frame_err=1, vec_count unchanged. The new vector is output bypassed with fst set, and completes with vec_count+1.
- Reset mid-vector with the FIFO holding 5 entries: pulse reset low.
  -> vld=0 immediately, FIFO empty, state WAIT_FST, counters 0. Next fst vector works.
- STATS_EN build: 3 ReLU vectors of 16 elements, 5 negatives each.
  -> zero_count=15. clear -> 0. Without the macro, zero_count stays 0 throughout.

Source files
------------

// File: rtl/full_st1_act_out_pkg.sv
// Shared types for the stage-1 activation output block: the float_24_8
// element format, its zero constant and the activation mode encoding.
// Used by full_st1_act_out and full_st1_act_fifo.
package full_st1_act_out_pkg;

    // Single-precision-style float: sign, 8-bit exponent, 23 stored mantissa
    // bits (24 with the hidden bit).
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_24_8;

    localparam int FLOAT_24_8_W = $bits(float_24_8);

    // All-zero encoding is +0.0; ReLU stores this for negative inputs.
    localparam float_24_8 FLOAT_24_8_ZERO = '0;

    typedef enum logic {
        ACT_BYPASS = 1'b0,
        ACT_RELU   = 1'b1
    } act_mode_t;

    // Width of one FIFO entry: element plus fst and mask flags.
    localparam int ACT_ENTRY_W = FLOAT_24_8_W + 2;

endpackage

// File: rtl/full_st1_act_fifo.sv
// Generic synchronous FIFO with a combinational view of the head entry.
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter. A write while full is dropped and a
// read while empty is ignored; there is no write-through when full.
module full_st1_act_fifo
    import full_st1_act_out_pkg::*;
#(
    parameter int WIDTH = ACT_ENTRY_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Same index with opposite wrap bits means the write side lapped the read side.
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Pointer advance; both may move in one cycle, leaving occupancy unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Storage array; contents need no reset since empty gates the head.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/full_st1_act_out.sv
// Stage-1 activation output block. Takes the stage-1 forward element stream,
// applies the per-vector activation (bypass or ReLU) at FIFO write, buffers
// results and presents them as the stage-2 stream with a ReLU derivative
// mask bit. A two-state framing FSM checks fst placement, raises a sticky
// frame_err and counts completed vectors.
// Optional build macro: FULL_ST1_ACT_OUT_STATS_EN enables zero_count, which
// counts FIFO writes whose mask is 0; without it zero_count is tied to 0.
module full_st1_act_out
    import full_st1_act_out_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int VEC_LEN = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  float_24_8   stage_1_data_out,
    input  logic        stage_1_data_out_fst,
    input  logic        stage_1_data_out_vld,
    output logic        stage_1_data_out_rdy,
    input  logic        act_mode,
    output float_24_8   stage_2_data,
    output logic        stage_2_data_fst,
    output logic        stage_2_data_mask,
    output logic        stage_2_data_vld,
    input  logic        stage_2_data_rdy,
    input  logic        clear,
    output logic        frame_err,
    output logic [15:0] vec_count,
    output logic [15:0] zero_count
);

    typedef enum logic {
        WAIT_FST = 1'b0,
        IN_VEC   = 1'b1
    } frame_state_t;

    localparam logic [15:0] VEC_LEN_U = 16'(VEC_LEN);
    localparam logic [15:0] ONE_U     = 16'd1;

    frame_state_t state_reg, state_next;
    logic [15:0]  index_reg, index_next;
    act_mode_t    mode_reg, mode_next;
    logic         live_reg;
    logic         frame_err_reg;
    logic [15:0]  vec_count_reg;

    logic         accept;
    logic         wr_en;
    logic         vec_done;
    logic         err_set;
    logic [15:0]  index_inc;
    act_mode_t    elem_mode;
    float_24_8    act_value;
    logic         act_mask;

    logic [ACT_ENTRY_W-1:0] fifo_wr_data;
    logic [ACT_ENTRY_W-1:0] fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    float_24_8              head_value;
    logic                   head_fst;
    logic                   head_mask;

    // rdy stays low while reset is held and rises on the first edge after release.
    assign stage_1_data_out_rdy = live_reg && !fifo_full;
    assign accept               = stage_1_data_out_vld && stage_1_data_out_rdy;
    assign index_inc            = index_reg + ONE_U;

    // Marks the block live one edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_reg <= 1'b0;
        end else begin
            live_reg <= 1'b1;
        end
    end

    // A first element uses the mode presented with it; the rest of the vector uses the latch.
    always_comb begin
        elem_mode = stage_1_data_out_fst ? act_mode_t'(act_mode) : mode_reg;
        act_value = stage_1_data_out;
        act_mask  = 1'b1;
        if (elem_mode == ACT_RELU && stage_1_data_out.sign) begin
            act_value = FLOAT_24_8_ZERO;
            act_mask  = 1'b0;
        end
    end

    assign fifo_wr_data = {act_value, stage_1_data_out_fst, act_mask};

    // Framing FSM next-state: decides write, error and vector completion per accepted element.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        mode_next  = mode_reg;
        wr_en      = 1'b0;
        vec_done   = 1'b0;
        err_set    = 1'b0;
        if (accept) begin
            if (stage_1_data_out_fst) begin
                // A fst inside a vector abandons the partial vector and restarts.
                err_set   = (state_reg == IN_VEC);
                wr_en     = 1'b1;
                mode_next = act_mode_t'(act_mode);
                if (VEC_LEN_U == ONE_U) begin
                    vec_done   = 1'b1;
                    index_next = '0;
                    state_next = WAIT_FST;
                end else begin
                    index_next = ONE_U;
                    state_next = IN_VEC;
                end
            end else if (state_reg == WAIT_FST) begin
                // Orphan element: consumed but dropped.
                err_set = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (index_inc == VEC_LEN_U) begin
                    vec_done   = 1'b1;
                    index_next = '0;
                    state_next = WAIT_FST;
                end else begin
                    index_next = index_inc;
                end
            end
        end
    end

    // Framing FSM state, element index and latched activation mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= WAIT_FST;
            index_reg <= '0;
            mode_reg  <= ACT_BYPASS;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            mode_reg  <= mode_next;
        end
    end

    // Sticky framing error and completed-vector count; a coinciding event beats clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_reg <= 1'b0;
            vec_count_reg <= '0;
        end else begin
            if (err_set) begin
                frame_err_reg <= 1'b1;
            end else if (clear) begin
                frame_err_reg <= 1'b0;
            end
            if (vec_done) begin
                vec_count_reg <= vec_count_reg + ONE_U;
            end else if (clear) begin
                vec_count_reg <= '0;
            end
        end
    end

    assign frame_err = frame_err_reg;
    assign vec_count = vec_count_reg;

`ifdef FULL_ST1_ACT_OUT_STATS_EN
    logic [15:0] zero_count_reg;

    // Counts elements zeroed by ReLU as they enter the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_count_reg <= '0;
        end else if (wr_en && !act_mask) begin
            zero_count_reg <= zero_count_reg + ONE_U;
        end else if (clear) begin
            zero_count_reg <= '0;
        end
    end

    assign zero_count = zero_count_reg;
`else
    assign zero_count = '0;
`endif

    full_st1_act_fifo #(
        .WIDTH (ACT_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (stage_2_data_rdy),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {head_value, head_fst, head_mask} = fifo_rd_data;

    // Head fields are forced to zero while the FIFO is empty so idle outputs read 0.
    assign stage_2_data_vld  = !fifo_empty;
    assign stage_2_data      = fifo_empty ? FLOAT_24_8_ZERO : head_value;
    assign stage_2_data_fst  = !fifo_empty && head_fst;
    assign stage_2_data_mask = !fifo_empty && head_mask;

endmodule
